// File: rtl/ahb_sram_slave_if.sv
// ahb_sram_slave_if: AHB-Lite bus bundle between the fabric wrapper (master) and the SRAM slave.
interface ahb_sram_slave_if;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hwbe;
    logic [31:0] hwdata;
    logic        hready;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;
    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hburst, hwbe, hwdata, hready,
        input  hreadyout, hresp, hrdata
    );
    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hburst, hwbe, hwdata, hready,
        output hreadyout, hresp, hrdata
    );
endinterface

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite SRAM slave with byte lanes and wait states; AHB_SRAM_ERR_EN enables the illegal-access ERROR response.
module ahb_sram_slave #(
    parameter int ADDR_W      = 12,
    parameter int WAIT_STATES = 1
) (
    input logic hclk,
    input logic hresetn,
    ahb_sram_slave_if.slave bus
);
    localparam int DEPTH = 1 << (ADDR_W - 2);
`ifdef AHB_SRAM_ERR_EN
    typedef enum logic [2:0] {IDLE, WAIT, DONE, ERR1, ERR2} state_t;
`else
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
`endif
    state_t            state, state_nxt;
    logic [31:0]       mem [DEPTH];
    logic [2:0]        cnt, cnt_nxt;
    logic              ph, ph_nxt;
    logic [ADDR_W-3:0] d_word, a_word;
    logic              d_write;
    logic [3:0]        d_mask, size_mask;
    logic              acc, illegal, commit;
    logic [31:0]       rd_word;
    logic              unused;
    assign unused = ^{bus.hburst, bus.haddr[31:ADDR_W]};
    always_comb begin
        acc       = bus.hsel & bus.hready & bus.htrans[1] & bus.hreadyout;
        a_word    = bus.haddr[ADDR_W-1:2];
        size_mask = bus.hsize == 3'd0 ? 4'b0001 << bus.haddr[1:0] :
                    bus.hsize == 3'd1 ? (bus.haddr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
`ifdef AHB_SRAM_ERR_EN
        illegal   = bus.hsize > 3'd2 || (bus.hsize == 3'd1 && bus.haddr[0]) ||
                    (bus.hsize == 3'd2 && bus.haddr[1:0] != 2'd0);
`else
        illegal   = 1'b0;
`endif
        commit    = ph & d_write & bus.hreadyout;
        for (int i = 0; i < 4; i++)
            rd_word[8*i +: 8] = (commit && d_mask[i] && d_word == a_word) ?
                                bus.hwdata[8*i +: 8] : mem[a_word][8*i +: 8];
    end
    always_comb begin
        state_nxt     = IDLE;
        cnt_nxt       = cnt;
`ifdef AHB_SRAM_ERR_EN
        bus.hresp     = state == ERR1 || state == ERR2;
        bus.hreadyout = state != WAIT && state != ERR1;
`else
        bus.hresp     = 1'b0;
        bus.hreadyout = state != WAIT;
`endif
        ph_nxt        = acc ? !illegal : ph & !bus.hreadyout;
        if (state == WAIT) begin
            state_nxt = cnt == 3'd0 ? DONE : WAIT;
            cnt_nxt   = cnt == 3'd0 ? 3'd0 : cnt - 3'd1;
        end
`ifdef AHB_SRAM_ERR_EN
        else if (state == ERR1)
            state_nxt = ERR2;
        else if (acc && illegal)
            state_nxt = ERR1;
`endif
        else if (acc) begin
            state_nxt = WAIT_STATES > 0 ? WAIT : IDLE;
            cnt_nxt   = 3'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
        end
    end
    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state      <= IDLE;
            cnt        <= 3'd0;
            ph         <= 1'b0;
            d_word     <= '0;
            d_write    <= 1'b0;
            d_mask     <= 4'd0;
            bus.hrdata <= 32'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            ph    <= ph_nxt;
            if (acc) begin
                d_word  <= a_word;
                d_write <= bus.hwrite;
                d_mask  <= size_mask & bus.hwbe;
            end
            if (acc && !illegal && !bus.hwrite)
                bus.hrdata <= rd_word;
        end
    end
    // Memory is not reset; a reset edge suppresses any pending write.
    always_ff @(posedge hclk) begin
        if (hresetn && commit)
            for (int i = 0; i < 4; i++)
                if (d_mask[i])
                    mem[d_word][8*i +: 8] <= bus.hwdata[8*i +: 8];
    end
endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave: directed checks of a 2-wait-state and a zero-wait-state ahb_sram_slave.
module tb_ahb_sram_slave;
    logic        hclk = 1'b0;
    logic        hresetn = 1'b0;
    logic        tgt = 1'b0, sel = 1'b0, hwrite = 1'b0;
    logic [31:0] haddr = 32'd0, hwdata = 32'd0;
    logic [1:0]  htrans = 2'd0;
    logic [2:0]  hsize = 3'd2;
    logic [3:0]  hwbe = 4'hF;
    logic        rdy, resp;
    logic [31:0] rdata;
    int          n_chk = 0, n_fail = 0;
    int          lows;
    logic [31:0] rd;
    logic        err;

    always #5 hclk = ~hclk;

    ahb_sram_slave_if b2();
    ahb_sram_slave_if b0();
    assign b2.hsel = sel & ~tgt;
    assign b0.hsel = sel & tgt;
    assign b2.haddr = haddr;   assign b0.haddr = haddr;
    assign b2.htrans = htrans; assign b0.htrans = htrans;
    assign b2.hwrite = hwrite; assign b0.hwrite = hwrite;
    assign b2.hsize = hsize;   assign b0.hsize = hsize;
    assign b2.hburst = 3'd0;   assign b0.hburst = 3'd0;
    assign b2.hwbe = hwbe;     assign b0.hwbe = hwbe;
    assign b2.hwdata = hwdata; assign b0.hwdata = hwdata;
    assign b2.hready = b2.hreadyout;
    assign b0.hready = b0.hreadyout;
    assign rdy   = tgt ? b0.hreadyout : b2.hreadyout;
    assign resp  = tgt ? b0.hresp : b2.hresp;
    assign rdata = tgt ? b0.hrdata : b2.hrdata;

    ahb_sram_slave #(.ADDR_W(12), .WAIT_STATES(2)) u_ws2 (.hclk(hclk), .hresetn(hresetn), .bus(b2));
    ahb_sram_slave #(.ADDR_W(12), .WAIT_STATES(0)) u_ws0 (.hclk(hclk), .hresetn(hresetn), .bus(b0));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic addr_phase(input logic t, input logic wr, input logic [31:0] a,
                              input logic [2:0] sz, input logic [3:0] be);
        tgt = t; sel = 1'b1; htrans = 2'd2; haddr = a; hwrite = wr; hsize = sz; hwbe = be;
    endtask

    // One transfer: address phase, then wait out the data phase; returns low cycles seen.
    task automatic xfer(input logic t, input logic wr, input logic [31:0] a, input logic [2:0] sz,
                        input logic [3:0] be, input logic [31:0] wd,
                        output int nlow, output logic [31:0] rdv, output logic e);
        @(negedge hclk);
        addr_phase(t, wr, a, sz, be);
        @(negedge hclk);
        sel = 1'b0; htrans = 2'd0; hwdata = wd;
        nlow = 0;
        e = resp;
        while (!rdy && nlow < 16) begin
            nlow++;
            @(negedge hclk);
            e = e | resp;
        end
        rdv = rdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int c = 0; c < 2; c++) begin
            @(negedge hclk);
            check("rst ws2 hreadyout", b2.hreadyout, 1);
            check("rst ws2 hresp", b2.hresp, 0);
            check("rst ws2 hrdata", b2.hrdata, 0);
            check("rst ws0 hreadyout", b0.hreadyout, 1);
            check("rst ws0 hresp", b0.hresp, 0);
            check("rst ws0 hrdata", b0.hrdata, 0);
        end
        hresetn = 1'b1;
        @(negedge hclk);
        tgt = 1'b0; sel = 1'b1; htrans = 2'd0;
        @(negedge hclk);
        check("idle hreadyout", b2.hreadyout, 1);
        check("idle hresp", b2.hresp, 0);
        htrans = 2'd1;
        @(negedge hclk);
        check("busy hreadyout", b2.hreadyout, 1);
        sel = 1'b0; htrans = 2'd0;

        xfer(0, 1, 32'h010, 3'd2, 4'hF, 32'hDEADBEEF, lows, rd, err);
        check("ws2 wr waits", lows, 2);
        check("ws2 wr resp", err, 0);
        xfer(0, 0, 32'h010, 3'd2, 4'hF, 32'h0, lows, rd, err);
        check("ws2 rd waits", lows, 2);
        check("ws2 rd data", rd, 32'hDEADBEEF);

        xfer(1, 1, 32'h020, 3'd2, 4'hF, 32'h11223344, lows, rd, err);
        check("ws0 init waits", lows, 0);
        @(negedge hclk);
        addr_phase(1, 1, 32'h023, 3'd0, 4'hF);
        @(negedge hclk);
        check("b2b wr ready", rdy, 1);
        hwdata = 32'hAA000000;
        addr_phase(1, 0, 32'h020, 3'd2, 4'hF);
        @(negedge hclk);
        sel = 1'b0; htrans = 2'd0;
        check("b2b rd ready", rdy, 1);
        check("b2b forward", rdata, 32'hAA223344);
        xfer(1, 0, 32'h020, 3'd2, 4'hF, 32'h0, lows, rd, err);
        check("b2b mem", rd, 32'hAA223344);

        xfer(0, 1, 32'h040, 3'd2, 4'hF, 32'hCAFEF00D, lows, rd, err);
        xfer(0, 1, 32'h042, 3'd1, 4'b0100, 32'h12340000, lows, rd, err);
        xfer(0, 0, 32'h040, 3'd2, 4'hF, 32'h0, lows, rd, err);
        check("half lane mask", rd, 32'hCA34F00D);

        xfer(1, 1, 32'h004, 3'd2, 4'hF, 32'h01020304, lows, rd, err);
`ifdef AHB_SRAM_ERR_EN
        @(negedge hclk);
        addr_phase(1, 1, 32'h005, 3'd2, 4'hF);
        @(negedge hclk);
        sel = 1'b0; htrans = 2'd0; hwdata = 32'hFFFFFFFF;
        check("err1 hreadyout", rdy, 0);
        check("err1 hresp", resp, 1);
        @(negedge hclk);
        check("err2 hreadyout", rdy, 1);
        check("err2 hresp", resp, 1);
        addr_phase(1, 0, 32'h004, 3'd2, 4'hF);
        @(negedge hclk);
        sel = 1'b0; htrans = 2'd0;
        check("post err hreadyout", rdy, 1);
        check("post err hresp", resp, 0);
        check("err no write", rdata, 32'h01020304);
`else
        xfer(1, 1, 32'h005, 3'd2, 4'hF, 32'hFFFFFFFF, lows, rd, err);
        check("unchk waits", lows, 0);
        check("unchk resp", err, 0);
        xfer(1, 0, 32'h004, 3'd2, 4'hF, 32'h0, lows, rd, err);
        check("unchk word write", rd, 32'hFFFFFFFF);
`endif

        xfer(0, 1, 32'h080, 3'd2, 4'hF, 32'h0BADF00D, lows, rd, err);
        @(negedge hclk);
        addr_phase(0, 1, 32'h080, 3'd2, 4'hF);
        @(negedge hclk);
        sel = 1'b0; htrans = 2'd0; hwdata = 32'h55555555;
        check("abort in wait", rdy, 0);
        hresetn = 1'b0;
        @(negedge hclk);
        check("abort hreadyout", rdy, 1);
        check("abort hresp", resp, 0);
        check("abort hrdata", rdata, 0);
        hresetn = 1'b1;
        xfer(0, 0, 32'h080, 3'd2, 4'hF, 32'h0, lows, rd, err);
        check("abort rd waits", lows, 2);
        check("abort no write", rd, 32'h0BADF00D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ahb_sram_slave.md
# ahb_sram_slave

AHB-Lite slave memory that sits directly downstream of the SoC FPGA AHB interface wrapper. It consumes the address/control/write-data signals that the wrapper drives toward the fabric, and returns HRDATA/HREADY/HRESP to it. The block holds a word-addressed register-array SRAM with byte-lane writes, programmable wait states, and a two-cycle ERROR response for illegal accesses.

## Interface
Parameters:
- ADDR_W, 12: byte-address bits decoded; depth is 2^(ADDR_W-2) 32-bit words; haddr[31:ADDR_W] ignored (aliasing).
- WAIT_STATES, 1: data-phase wait cycles, legal range 0..7.

Ports:
- hclk  in  1  clock; all logic on rising edge.
- hresetn  in  1  reset; synchronous, active-low.
- hsel  in  1  slave select.
- haddr  in  32  byte address.
- htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- hwrite  in  1  1=write.
- hsize  in  3  0=byte, 1=half, 2=word; larger values are illegal.
- hburst  in  3  accepted, not decoded (every beat carries its own haddr).
- hwbe  in  4  write byte enables, ANDed with the size-derived lane mask.
- hwdata  in  32  write data, data phase.
- hready  in  1  bus-level ready; qualifies address-phase sampling.
- hreadyout  out  1  slave ready.
- hresp  out  1  0=OKAY, 1=ERROR.
- hrdata  out  32  read data.

## Operation
- Accept: an address phase is taken on the rising edge where hsel & hready & htrans[1]. haddr, hwrite, hsize and hwbe are latched at that edge.
- IDLE and BUSY transfers, or hsel=0, get a zero-wait OKAY. No state change.
- Legality check with AHB_SRAM_ERR_EN:
  - hsize>2 is illegal.
  - hsize=1 with haddr[0]=1 is illegal.
  - hsize=2 with haddr[1:0]≠0 is illegal.
- FSM states:
  - IDLE: legal accept goes to WAIT if WAIT_STATES>0, otherwise stays in IDLE (zero-wait completion). Illegal accept goes to ERR1.
  - WAIT: counter loaded with WAIT_STATES-1 on accept. hreadyout=0. When the counter reaches 0, go to DONE.
  - DONE: hreadyout=1. A new accept in this cycle is evaluated exactly as from IDLE; otherwise go to IDLE.
  - ERR1: hreadyout=0, hresp=1; go to ERR2.
  - ERR2: hreadyout=1, hresp=1. Accepts are evaluated as from IDLE. An illegal transfer never writes memory.
- Write lanes:
  - Byte: one lane selected by haddr[1:0].
  - Half: lanes 1:0 or 3:2, selected by haddr[1].
  - Word: all four lanes.
  - Final mask = size mask & latched hwbe.
  - The write commits on the data-phase cycle in which hreadyout=1, using hwdata sampled at that edge.
- Reads:
  - hrdata is loaded at the accept edge from the array word at haddr[ADDR_W-1:2].
  - If a write commits on that same edge, its masked bytes are forwarded into hrdata, so back-to-back write→read to the same word returns the new data.
  - hrdata holds its value until the next read accept.

## Timing
- Reset values (hresetn=0 at an edge): state IDLE, hreadyout=1, hresp=0, hrdata=0, wait counter 0. Memory contents are not reset.
- Reset asserted mid-data-phase aborts the transfer. A pending write is not committed.
- Latency for a legal transfer accepted at edge N:
  - hreadyout is low for cycles N+1 .. N+WAIT_STATES.
  - hreadyout is high in cycle N+1+WAIT_STATES.
  - With WAIT_STATES=0, completion is in cycle N+1 with no low cycle.
- Error response: exactly 2 cycles. The first has hreadyout=0, hresp=1; the second has hreadyout=1, hresp=1.
- hresp=0 in every cycle that is not ERR1 or ERR2.
- An address phase is never accepted while hreadyout=0 (hready is low).

## Configuration
- AHB_SRAM_ERR_EN defined: legality check active; ERR1/ERR2 reachable.
- AHB_SRAM_ERR_EN undefined:
  - No check is performed; hresp is constant 0 and ERR states are removed.
  - hsize>2 is treated as a word access.
  - Misaligned addresses use haddr[1:0] for lane selection exactly as decoded above.

## Test plan
- Reset then idle: hresetn=0 for 2 cycles, htrans=IDLE → hreadyout=1, hresp=0, hrdata=0 every cycle.
- WAIT_STATES=2, word write 0xDEADBEEF @0x010, then word read @0x010 → each transfer shows hreadyout low for 2 cycles; read returns 0xDEADBEEF.
- WAIT_STATES=0, back-to-back byte write 0xAA @0x023 (hwbe=4'hF) then word read @0x020 → completes in one cycle each; hrdata[31:24]=0xAA with the other bytes unchanged (forwarding).
- Half write 0x1234 @0x042 with hwbe=4'b0100 → only byte 2=0x34 is written; a word read @0x040 shows byte 3 unchanged.
- With AHB_SRAM_ERR_EN, word write @0x005:
  - Response is hreadyout=0/hresp=1, then hreadyout=1/hresp=1.
  - Memory @0x004 is unchanged.
  - A NONSEQ read accepted in ERR2 completes OKAY.
- Reset asserted during the WAIT cycle of a write 0x55555555 @0x080 → after reset, reading @0x080 returns the old contents; hreadyout=1 immediately after reset.
